// File: rtl/sram_arbiter.sv
// Two-requester arbiter and sequencer for a 16x8 single-port synchronous SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module sram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] WDATA0,
    output logic              GNT0,
    output logic              RVALID0,
    output logic [DATA_W-1:0] RDATA0,
    input  logic              REQ1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT1,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA1,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WREN,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    logic prio0;

`ifdef SRAM_ARB_RR_EN
    // last_q = 1 means requester 1 was granted last, so requester 0 wins the next tie
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (GNT0)
            last_d = 1'b0;
        else if (GNT1)
            last_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end

    assign prio0 = last_q;
`else
    assign prio0 = 1'b1;
`endif

    assign GNT0 = !RST && REQ0 && (!REQ1 || prio0);
    assign GNT1 = !RST && REQ1 && !GNT0;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wren_q, mem_wren_d;
    logic              rd1_q, rd1_d, own1_q, own1_d;
    logic              rd2_q, own2_q;

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
        if (GNT0) begin
            mem_addr_d  = ADDR0;
            mem_wdata_d = WDATA0;
            mem_wren_d  = WE0;
        end else if (GNT1) begin
            mem_addr_d  = ADDR1;
            mem_wdata_d = WDATA1;
            mem_wren_d  = WE1;
        end
        rd1_d  = (GNT0 && !WE0) || (GNT1 && !WE1);
        own1_d = GNT1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            rd1_q       <= 1'b0;
            own1_q      <= 1'b0;
            rd2_q       <= 1'b0;
            own2_q      <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            rd1_q       <= rd1_d;
            own1_q      <= own1_d;
            rd2_q       <= rd1_q;
            own2_q      <= own1_q;
        end
    end

    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_WREN  = mem_wren_q;

    // Read data comes straight from the SRAM in the cycle its stage-2 entry is valid
    assign RVALID0 = rd2_q && !own2_q;
    assign RVALID1 = rd2_q && own2_q;
    assign RDATA0  = RVALID0 ? MEM_RDATA : '0;
    assign RDATA1  = RVALID1 ? MEM_RDATA : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 16x8 synchronous SRAM.
// Expectations follow SRAM_ARB_RR_EN when the bench is built with that macro.
module tb_sram_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, WE0, REQ1, WE1;
    logic [3:0] ADDR0, ADDR1;
    logic [7:0] WDATA0, WDATA1;
    logic       GNT0, GNT1, RVALID0, RVALID1;
    logic [7:0] RDATA0, RDATA1;
    logic [3:0] MEM_ADDR;
    logic [7:0] MEM_WDATA;
    logic       MEM_WREN;
    logic [7:0] MEM_RDATA;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
        .GNT0(GNT0), .RVALID0(RVALID0), .RDATA0(RDATA0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
        .GNT1(GNT1), .RVALID1(RVALID1), .RDATA1(RDATA1),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WREN(MEM_WREN),
        .MEM_RDATA(MEM_RDATA)
    );

    // SRAM model: read data holds during write cycles
    logic [7:0] mem [16];
    always @(posedge CLK) begin
        if (MEM_WREN)
            mem[MEM_ADDR] <= MEM_WDATA;
        else
            MEM_RDATA <= mem[MEM_ADDR];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic drv0(input logic req, input logic we, input logic [3:0] a, input logic [7:0] d);
        REQ0 = req; WE0 = we; ADDR0 = a; WDATA0 = d;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [3:0] a, input logic [7:0] d);
        REQ1 = req; WE1 = we; ADDR1 = a; WDATA1 = d;
    endtask

    task automatic idle();
        drv0(1'b0, 1'b0, 4'h0, 8'h00);
        drv1(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"}, 8'(GNT0), 8'h0);
        chk({tag, "_gnt1"}, 8'(GNT1), 8'h0);
        chk({tag, "_rv0"}, 8'(RVALID0), 8'h0);
        chk({tag, "_rv1"}, 8'(RVALID1), 8'h0);
        chk({tag, "_rd0"}, RDATA0, 8'h00);
        chk({tag, "_rd1"}, RDATA1, 8'h00);
        chk({tag, "_maddr"}, 8'(MEM_ADDR), 8'h0);
        chk({tag, "_mwdata"}, MEM_WDATA, 8'h00);
        chk({tag, "_mwren"}, 8'(MEM_WREN), 8'h0);
    endtask

    logic exp_g0, exp_rv0, exp_rv1;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        MEM_RDATA = 8'h00;
        RST = 1'b1;
        idle();
        REQ0 = 1'b1;

        // Reset: grants gated even with a request pending
        adv();
        adv();
        settle();
        chk_all_zero("reset");
        adv();

        // Write 0xA5 to 0x3, then read it back on requester 0
        RST = 1'b0;
        drv0(1'b1, 1'b1, 4'h3, 8'hA5);
        settle();
        chk("wr3_gnt0", 8'(GNT0), 8'h1);
        chk("wr3_gnt1", 8'(GNT1), 8'h0);
        adv();
        drv0(1'b1, 1'b0, 4'h3, 8'h00);
        settle();
        chk("rd3_gnt0", 8'(GNT0), 8'h1);
        chk("wr3_mwren", 8'(MEM_WREN), 8'h1);
        chk("wr3_maddr", 8'(MEM_ADDR), 8'h3);
        chk("wr3_mwdata", MEM_WDATA, 8'hA5);
        adv();
        idle();
        settle();
        chk("rd3_rv0_early", 8'(RVALID0), 8'h0);
        adv();
        settle();
        chk("rd3_rv0", 8'(RVALID0), 8'h1);
        chk("rd3_rdata0", RDATA0, 8'hA5);
        chk("rd3_rv1", 8'(RVALID1), 8'h0);
        adv();
        settle();
        chk("rd3_rv0_once", 8'(RVALID0), 8'h0);
        adv();

        // Requester 1 writes 0x5A to 0xF, requester 0 reads it the next cycle
        drv1(1'b1, 1'b1, 4'hF, 8'h5A);
        settle();
        chk("wrF_gnt1", 8'(GNT1), 8'h1);
        chk("wrF_gnt0", 8'(GNT0), 8'h0);
        adv();
        drv1(1'b0, 1'b0, 4'h0, 8'h00);
        drv0(1'b1, 1'b0, 4'hF, 8'h00);
        settle();
        chk("rdF_gnt0", 8'(GNT0), 8'h1);
        adv();
        idle();
        settle();
        adv();
        settle();
        chk("rdF_rv0", 8'(RVALID0), 8'h1);
        chk("rdF_rdata0", RDATA0, 8'h5A);
        adv();

        // Preload 0x0..0x7 with 0x10..0x17 through requester 1
        for (int i = 0; i < 8; i++) begin
            drv1(1'b1, 1'b1, 4'(i), 8'(8'h10 + i));
            settle();
            chk("pre_gnt1", 8'(GNT1), 8'h1);
            adv();
        end
        idle();
        adv();

        // Both requesters hold reads for 4 cycles
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                drv0(1'b1, 1'b0, 4'h0, 8'h00);
                drv1(1'b1, 1'b0, 4'h1, 8'h00);
            end else begin
                idle();
            end
            settle();
`ifdef SRAM_ARB_RR_EN
            exp_g0 = (k % 2 == 0);
`else
            exp_g0 = 1'b1;
`endif
            if (k < 4) begin
                chk("both_gnt0", 8'(GNT0), 8'(exp_g0));
                chk("both_gnt1", 8'(GNT1), 8'(!exp_g0));
            end
            if (k >= 2) begin
`ifdef SRAM_ARB_RR_EN
                exp_rv0 = ((k - 2) % 2 == 0);
                exp_rv1 = ((k - 2) % 2 == 1);
`else
                exp_rv0 = 1'b1;
                exp_rv1 = 1'b0;
`endif
                chk("both_rv0", 8'(RVALID0), 8'(exp_rv0));
                chk("both_rv1", 8'(RVALID1), 8'(exp_rv1));
                chk("both_rd0", RDATA0, exp_rv0 ? 8'h10 : 8'h00);
                chk("both_rd1", RDATA1, exp_rv1 ? 8'h11 : 8'h00);
            end
            adv();
        end
        idle();
        adv();

        // Requester 0 streams reads of 0x0..0x7
        for (int k = 0; k < 11; k++) begin
            if (k < 8)
                drv0(1'b1, 1'b0, 4'(k), 8'h00);
            else
                idle();
            settle();
            if (k < 8)
                chk("strm_gnt0", 8'(GNT0), 8'h1);
            chk("strm_mwren", 8'(MEM_WREN), 8'h0);
            if (k >= 2 && k < 10) begin
                chk("strm_rv0", 8'(RVALID0), 8'h1);
                chk("strm_rd0", RDATA0, 8'(8'h10 + (k - 2)));
            end else begin
                chk("strm_rv0_off", 8'(RVALID0), 8'h0);
            end
            adv();
        end

        // Reset one cycle after a read grant drops the pending RVALID
        drv0(1'b1, 1'b0, 4'h5, 8'h00);
        settle();
        chk("rst_rd_gnt0", 8'(GNT0), 8'h1);
        adv();
        idle();
        RST = 1'b1;
        settle();
        chk("rst_cyc_rv0", 8'(RVALID0), 8'h0);
        adv();
        RST = 1'b0;
        settle();
        chk_all_zero("post_rst");
        adv();
        settle();
        chk("post_rst_rv0", 8'(RVALID0), 8'h0);
        adv();
        drv0(1'b1, 1'b0, 4'h5, 8'h00);
        settle();
        chk("post_rst_gnt0", 8'(GNT0), 8'h1);
        adv();
        idle();
        settle();
        adv();
        settle();
        chk("post_rst_rv0_rd", 8'(RVALID0), 8'h1);
        chk("post_rst_rd0", RDATA0, 8'h15);
        adv();

        // Write followed by 5 idle cycles: address/data hold, write enable drops
        drv1(1'b1, 1'b1, 4'h9, 8'h3C);
        settle();
        chk("idle_wr_gnt1", 8'(GNT1), 8'h1);
        adv();
        idle();
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("idle_mwren", 8'(MEM_WREN), (k == 0) ? 8'h1 : 8'h0);
            chk("idle_maddr", 8'(MEM_ADDR), 8'h9);
            chk("idle_mwdata", MEM_WDATA, 8'h3C);
            chk("idle_rv0", 8'(RVALID0), 8'h0);
            chk("idle_rv1", 8'(RVALID1), 8'h0);
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and sequencer for the 16x8 single-port synchronous SRAM.
- Accepts one read or write command per cycle from either requester. Drives the SRAM port (address, write data, write enable) from registered outputs.
- Returns read data to the requester that issued the read, with a fixed latency.
- Sits between two client engines and one SRAM instance, so both clients share the single port without conflict.

Parameters:
ADDR_W, 4, SRAM address width (16 words)
DATA_W, 8, SRAM data width

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
REQ0  input  1  requester 0 command valid
WE0  input  1  requester 0: 1 = write, 0 = read
ADDR0  input  ADDR_W  requester 0 address
WDATA0  input  DATA_W  requester 0 write data
GNT0  output  1  requester 0 command accepted this cycle
RVALID0  output  1  requester 0 read data valid
RDATA0  output  DATA_W  requester 0 read data
REQ1, WE1, ADDR1, WDATA1, GNT1, RVALID1, RDATA1: same as above, for requester 1
MEM_ADDR  output  ADDR_W  to SRAM address, registered
MEM_WDATA  output  DATA_W  to SRAM write data, registered
MEM_WREN  output  1  to SRAM write enable, registered
MEM_RDATA  input  DATA_W  from SRAM read data

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - GNT0/1 = 0 (gated combinationally while RST = 1).
  - RVALID0/1 = 0 and RDATA0/1 = 0.
  - MEM_ADDR = 0, MEM_WDATA = 0, MEM_WREN = 0.
  - Arbitration pointer favours requester 0.
- Handshake:
  - REQi/WEi/ADDRi/WDATAi must be held stable until the cycle GNTi = 1.
  - A command transfers when REQi and GNTi are both high.
  - GNTi is combinational from REQ and the arbitration state.
  - At most one GNT is high per cycle.
  - Throughput is 1 command per cycle.
- Arbitration: only one REQ high -> that requester is granted. Both high -> winner per the Optional Feature.
- Issue (grant in cycle t):
  - At the end of t, MEM_ADDR/MEM_WDATA/MEM_WREN load the winner's ADDR/WDATA/WE.
  - The SRAM samples them at the end of t+1.
- Idle cycle (no grant): MEM_WREN loads 0; MEM_ADDR and MEM_WDATA hold their value. The resulting SRAM read is harmless and is not reported.
- Read return:
  - A 2-stage owner/valid pipeline tracks each granted read.
  - RVALIDi = 1 in cycle t+2 for exactly one cycle.
  - RDATAi = MEM_RDATA while RVALIDi = 1, else 0.
  - Back-to-back reads produce back-to-back RVALIDs, in grant order.
- Writes: no acknowledge beyond GNT. The write is complete in the SRAM at the end of t+1.
- Hazards:
  - A write followed by a read to the same address in the next grant cycle returns the new data. The write lands at end of t+1; the read samples at end of t+2.
  - No bypass is required.
  - A write never disturbs an in-flight RVALID. The SRAM holds RDATA during write cycles.
- Reset mid-operation:
  - Pending RVALIDs are dropped and never asserted.
  - A write already presented on MEM_* in the cycle RST first samples high completes at that edge.
  - A command granted in that same cycle is discarded.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. A 1-bit pointer holds the last-granted requester.
  - When both request, the requester not granted last wins.
  - The pointer updates only on a grant.
- Undefined: fixed priority. Requester 0 always wins; the pointer logic is absent.

Test Plan:
- Reset, then REQ0 write to ADDR 0x3 with 0xA5; next grant REQ0 read of 0x3 -> GNT0 in each request cycle; RVALID0 2 cycles after the read grant with RDATA0 = 0xA5; RVALID1 stays 0.
- Requester 1 writes 0x5A to 0xF, then requester 0 reads 0xF on the immediately following cycle -> RDATA0 = 0x5A, proving no read-after-write hazard.
- Both REQ held high for 4 cycles, reading addresses 0x0 and 0x1 (preloaded 0x10 and 0x11):
  - With SRAM_ARB_RR_EN: GNT order 0,1,0,1, and RVALID0/RVALID1 alternate with 0x10/0x11.
  - Without the macro: GNT0 for all 4 cycles, GNT1 = 0.
- Requester 0 streams 8 consecutive reads of 0x0..0x7 -> 8 consecutive RVALID0 cycles with data in address order; MEM_WREN = 0 throughout.
- RST asserted one cycle after a read grant -> RVALID0 never asserts; all outputs read 0 on the cycle after the reset edge; a subsequent read returns the pre-reset contents.
- No requests for 5 cycles after a write -> MEM_WREN = 0; MEM_ADDR and MEM_WDATA hold the last values; no RVALID asserted.
